dmem_responder: RTL and testbench

//  Data-memory responder on the memory side of the CPU load/store port. It accepts one
//  lw/sw request at a time from the pipeline's MEM stage over a valid/ready handshake,

---
 rtl/mips_mem_pkg.sv | 28 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t     : responder FSM states
//   dmem_req_t  : one latched load/store request
//   WORD_BYTES  : bytes per storage word; BE_W : byte-enable width
//   ERR_*       : error-code bits; any nonzero code sets rsp_err
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BE_W       = WORD_BYTES;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  typedef struct packed {
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage array with per-byte write enables.
// Writes are synchronous to clk; the read port is combinational so the
// responder can register load data on the same edge that performs the access.
// Contents are not reset.
//   clk     : system clock
//   i_we    : per-byte write enable (bit i = byte i)
//   i_addr  : word index (shared by read and write)
//   i_wdata : write data
//   o_rdata : word at i_addr
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [BE_W-1:0] i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port.
// Accepts one lw/sw request at a time (valid/ready), waits LATENCY cycles,
// then presents read data or a write acknowledge until the pipeline takes it.
// Optional build macro: DMEM_ALIGN_CHECK_EN -- when defined, addresses with
// addr[1:0] != 0 are rejected; otherwise the low bits are ignored.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   req_valid : request present          req_ready : can accept this cycle
//   req_we    : 1 = store, 0 = load      req_addr  : byte address
//   req_wdata : store data               req_be    : store byte enables
//   rsp_valid : response present         rsp_ready : pipeline takes response
//   rsp_rdata : load data (0 for stores/errors)
//   rsp_err   : out of range / misaligned
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  dmem_req_t       r_req;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [31:0]     r_rsp_rdata;

  dmem_req_t       w_acc;
  logic            w_accept;
  logic            w_fire;
  logic [1:0]      w_err_code;
  logic            w_err;
  logic [BE_W-1:0] w_we;
  logic [31:0]     w_rdata;

  assign w_accept = req_valid && r_req_ready && (r_state == IDLE);

  // The access uses the live request only when LATENCY==1 (access on the
  // accept edge); otherwise it uses the request latched at accept.
  always_comb begin
    w_acc = r_req;
    if (r_state == IDLE) begin
      w_acc.we    = req_we;
      w_acc.addr  = req_addr;
      w_acc.wdata = req_wdata;
      w_acc.be    = req_be;
    end
  end

  assign w_fire = ((r_state == WAIT) && (r_cnt == '0)) ||
                  ((LATENCY == 1) && w_accept);

  always_comb begin
    w_err_code = ERR_NONE;
    if (|w_acc.addr[31:AW+2]) w_err_code = w_err_code | ERR_RANGE;
`ifdef DMEM_ALIGN_CHECK_EN
    if (|w_acc.addr[1:0]) w_err_code = w_err_code | ERR_ALIGN;
`else
    // Byte offset ignored: misaligned addresses hit the containing word.
    if (1'b0 & (|w_acc.addr[1:0])) w_err_code = w_err_code | ERR_ALIGN;
`endif
  end

  assign w_err = |w_err_code;

  // Rejected stores never reach the array.
  assign w_we = (w_fire && w_acc.we && !w_err) ? w_acc.be : '0;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_acc.addr[AW+1:2]),
    .i_wdata (w_acc.wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req       <= w_acc;
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_rsp_rdata <= (w_err || w_acc.we) ? '0 : w_rdata;
            end else begin
              r_cnt   <= CW'(LATENCY - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || w_acc.we) ? '0 : w_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized
// load/store mix checked against a word-addressed memory model.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference memory: word index -> contents (only words the bench wrote).
  logic [31:0] mm [int];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    bit e;
    e = (a >= 32'(DEPTH * 4));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One request/response. hold = cycles rsp_ready stays low in RESP;
  // pulse = drive a stray store to 0x40 during the hold.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, input bit pulse,
                        output logic [31:0] rd, output logic er, output int lat);
    int t;
    rd = '0; er = 1'b0; lat = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      chk("req_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 50);
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    rd = rsp_rdata; er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = '1; req_be = 4'hF;
      end else req_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", 32'(rsp_err), 32'(er));
      chk("hold_reqrdy", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (hold > 0) chk("rsp_taken", 32'(rsp_valid), 32'd0);
  endtask

  // Request + checks against the model; updates the model on good stores.
  task automatic op(input string tag, input logic we, input logic [31:0] a,
                    input logic [31:0] wd, input logic [3:0] be, input int hold, input bit pulse);
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          e;
    int          i;
    do_req(we, a, wd, be, hold, pulse, rd, er, lat);
    if (lat < 0) return;
    e = exp_err(a);
    i = widx(a);
    chk({tag, "_lat"}, 32'(lat), 32'(LATENCY));
    chk({tag, "_err"}, 32'(er), 32'(e));
    if (we || e) chk({tag, "_rdata0"}, rd, 32'h0);
    else if (mm.exists(i)) chk({tag, "_rdata"}, rd, mm[i]);
    if (we && !e) begin
      logic [31:0] w;
      w = mm.exists(i) ? mm[i] : 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      mm[i] = w;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_reqrdy", 32'(req_ready), 32'd0);
    chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_reqrdy", 32'(req_ready), 32'd1);

    // Full store / load, then byte-merge store
    op("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    op("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    op("st_byte", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0);
    op("ld_byte", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    chk("merge_val", mm[widx(32'h10)], 32'hDEADBEAA);

    // Out-of-range: 0x1000 would alias word 0 if the range check were missing
    op("st_w0", 1'b1, 32'h0, 32'h11111111, 4'hF, 0, 1'b0);
    op("ld_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0);
    op("st_oor", 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    op("ld_w0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
    op("ld_10b", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

    // Backpressure in RESP with a stray request pulse that must be ignored
    op("st_40", 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 0, 1'b0);
    op("ld_hold", 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
    op("ld_40", 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0);

    // Reset during WAIT of a store aborts the write
    op("st_20", 1'b1, 32'h20, 32'h12345678, 4'hF, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFF0000; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rstw_rspvalid", 32'(rsp_valid), 32'd0);
    chk("rstw_reqrdy", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rstw_reqrdy1", 32'(req_ready), 32'd1);
    chk("rstw_rspvalid1", 32'(rsp_valid), 32'd0);
    op("ld_20", 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    // Misaligned load
    op("ld_12", 1'b0, 32'h12, 32'h0, 4'h0, 0, 1'b0);

    // Randomized mix over 16 known words, with misaligned and out-of-range hits
    for (int k = 0; k < 16; k++) op("rinit", 1'b1, 32'(k * 4), $urandom, 4'hF, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      op("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
         $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
